in_spike_buf_ctrl: RTL and testbench

Per-time-step sequencer for the input spike buffer of one neuron core.
- On a time-step tick it loads fresh spikes into the recall buffer.
- It then sweeps every axon address on the recall read port. In parallel it sweeps the learning read port, which holds the previous step's spikes.
- Once both sweeps finish, it commits recall spikes into the learning buffer.
- It sits between the core's step controller and the input spike buffer, and feeds the crossbar/learning datapaths through valid/ready handshakes.

---
 rtl/in_spike_buf_ctrl_pkg.sv | 16 +
 rtl/in_spike_buf_ctrl_sweep.sv | 63 ++++++
 rtl/in_spike_buf_ctrl.sv | 103 ++++++++++
 tb/tb_in_spike_buf_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/in_spike_buf_ctrl_pkg.sv
// Shared types and constants for the input spike buffer sequencer.
package in_spike_buf_ctrl_pkg;

  localparam int AXON_CNT_BIT_WIDTH_DEF = 8;
  localparam int LOAD_CYCLES            = 1;
  localparam int READ_LATENCY           = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SWEEP = 3'd2,
    SAVE  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/in_spike_buf_ctrl_sweep.sv
// Address sweep engine: issues axon addresses 0..NUM_AXONS-1 under a ready
// handshake and delays issued reads by the buffer read latency.
module axon_sweep_cnt
  import in_spike_buf_ctrl_pkg::*;
#(
  parameter int NUM_AXONS          = 256,
  parameter int AXON_CNT_BIT_WIDTH = AXON_CNT_BIT_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          skip_i,
  input  logic                          clr_i,
  input  logic                          rdy_i,
  output logic                          rdEn_o,
  output logic [AXON_CNT_BIT_WIDTH-1:0] addr_o,
  output logic                          finished_o,
  output logic                          spikeVld_o,
  output logic [AXON_CNT_BIT_WIDTH-1:0] addrVld_o
);

  localparam logic [AXON_CNT_BIT_WIDTH-1:0] LAST_ADDR = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

  logic                          finished;
  logic [READ_LATENCY-1:0]       vldPipe;
  logic [AXON_CNT_BIT_WIDTH-1:0] addrPipe [READ_LATENCY];

  assign rdEn_o = en_i & ~skip_i & ~finished & rdy_i;
  // Includes the read issuing the last address so the FSM can leave in the next cycle.
  assign finished_o = finished | skip_i | (rdEn_o & (addr_o == LAST_ADDR));

  // A flag marks completion so the counter never has to wrap when NUM_AXONS fills the width.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_o   <= '0;
      finished <= 1'b0;
    end else if (clr_i) begin
      addr_o   <= '0;
      finished <= 1'b0;
    end else if (rdEn_o) begin
      if (addr_o == LAST_ADDR) finished <= 1'b1;
      else                     addr_o   <= addr_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vldPipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) addrPipe[i] <= '0;
    end else begin
      vldPipe[0]  <= rdEn_o;
      addrPipe[0] <= addr_o;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vldPipe[i]  <= vldPipe[i-1];
        addrPipe[i] <= addrPipe[i-1];
      end
    end
  end

  assign spikeVld_o = vldPipe[READ_LATENCY-1];
  assign addrVld_o  = addrPipe[READ_LATENCY-1];

endmodule

// File: rtl/in_spike_buf_ctrl.sv
// Per-time-step sequencer: load recall buffer, sweep recall and learning read
// ports, then commit recall spikes into the learning buffer.
module in_spike_buf_ctrl
  import in_spike_buf_ctrl_pkg::*;
#(
  parameter int NUM_AXONS          = 256,
  parameter int AXON_CNT_BIT_WIDTH = AXON_CNT_BIT_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          tick_i,
  input  logic                          lrnEn_i,
  input  logic                          rclRdy_i,
  input  logic                          lrnRdy_i,
  output logic                          start_o,
  output logic [AXON_CNT_BIT_WIDTH-1:0] RclAxonAddr_o,
  output logic                          rdEn_RclInSpike_o,
  output logic                          rclSpikeVld_o,
  output logic [AXON_CNT_BIT_WIDTH-1:0] rclAddrVld_o,
  output logic                          saveRclSpikes_o,
  output logic [AXON_CNT_BIT_WIDTH-1:0] LrnAxonAddr_o,
  output logic                          rdEn_LrnInSpike_o,
  output logic                          lrnSpikeVld_o,
  output logic [AXON_CNT_BIT_WIDTH-1:0] lrnAddrVld_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overrun_o,
  output logic [2:0]                    dbgState_o
);

  state_t     state, stateNext;
  logic       lrnAct;
  logic [3:0] loadCnt;
  logic       sweepEn, cntClr, rclFin, lrnFin;

  assign sweepEn    = (state == SWEEP);
  assign cntClr     = (state == DONE);
  assign dbgState_o = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      lrnAct  <= 1'b0;
      loadCnt <= '0;
    end else begin
      state   <= stateNext;
      if (state == IDLE && tick_i) lrnAct <= lrnEn_i;
      loadCnt <= (state == LOAD) ? loadCnt + 1'b1 : '0;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (tick_i) stateNext = LOAD;
      LOAD:    if (loadCnt == 4'(LOAD_CYCLES - 1)) stateNext = SWEEP;
      SWEEP:   if (rclFin && lrnFin) stateNext = SAVE;
      SAVE:    stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Ticks are only accepted in IDLE; any other tick is dropped and flagged.
  always_comb begin
    start_o         = (state == LOAD);
    saveRclSpikes_o = (state == SAVE);
    done_o          = (state == DONE);
    busy_o          = (state != IDLE);
    overrun_o       = tick_i & (state != IDLE);
  end

  // Handshake: a read is issued (rdEn high) exactly in cycles where the engine has an
  // address pending and the consumer's ready is high; the address then advances.
  axon_sweep_cnt #(.NUM_AXONS(NUM_AXONS), .AXON_CNT_BIT_WIDTH(AXON_CNT_BIT_WIDTH)) u_rcl (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (sweepEn),
    .skip_i     (1'b0),
    .clr_i      (cntClr),
    .rdy_i      (rclRdy_i),
    .rdEn_o     (rdEn_RclInSpike_o),
    .addr_o     (RclAxonAddr_o),
    .finished_o (rclFin),
    .spikeVld_o (rclSpikeVld_o),
    .addrVld_o  (rclAddrVld_o)
  );

  axon_sweep_cnt #(.NUM_AXONS(NUM_AXONS), .AXON_CNT_BIT_WIDTH(AXON_CNT_BIT_WIDTH)) u_lrn (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (sweepEn),
    .skip_i     (~lrnAct),
    .clr_i      (cntClr),
    .rdy_i      (lrnRdy_i),
    .rdEn_o     (rdEn_LrnInSpike_o),
    .addr_o     (LrnAxonAddr_o),
    .finished_o (lrnFin),
    .spikeVld_o (lrnSpikeVld_o),
    .addrVld_o  (lrnAddrVld_o)
  );

endmodule

// File: tb/tb_in_spike_buf_ctrl.sv
// Directed and randomised step sequences for in_spike_buf_ctrl with an address scoreboard.
module tb_in_spike_buf_ctrl;
  import in_spike_buf_ctrl_pkg::*;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n, tick, lrnEn, rclRdy, lrnRdy;
  logic         start_o, rdEn_RclInSpike_o, rclSpikeVld_o, saveRclSpikes_o;
  logic         rdEn_LrnInSpike_o, lrnSpikeVld_o, busy_o, done_o, overrun_o;
  logic [W-1:0] RclAxonAddr_o, rclAddrVld_o, LrnAxonAddr_o, lrnAddrVld_o;
  logic [2:0]   dbgState_o;

  int nAsserts = 0;
  int nFail    = 0;
  logic [W-1:0] rcl_q[$];
  logic [W-1:0] lrn_q[$];

  always #5 clk = ~clk;

  in_spike_buf_ctrl #(.NUM_AXONS(N), .AXON_CNT_BIT_WIDTH(W)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .tick_i            (tick),
    .lrnEn_i           (lrnEn),
    .rclRdy_i          (rclRdy),
    .lrnRdy_i          (lrnRdy),
    .start_o           (start_o),
    .RclAxonAddr_o     (RclAxonAddr_o),
    .rdEn_RclInSpike_o (rdEn_RclInSpike_o),
    .rclSpikeVld_o     (rclSpikeVld_o),
    .rclAddrVld_o      (rclAddrVld_o),
    .saveRclSpikes_o   (saveRclSpikes_o),
    .LrnAxonAddr_o     (LrnAxonAddr_o),
    .rdEn_LrnInSpike_o (rdEn_LrnInSpike_o),
    .lrnSpikeVld_o     (lrnSpikeVld_o),
    .lrnAddrVld_o      (lrnAddrVld_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .overrun_o         (overrun_o),
    .dbgState_o        (dbgState_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, start_o, 0);
    chk({tag, "_rcl_addr"}, RclAxonAddr_o, 0);
    chk({tag, "_rcl_rden"}, rdEn_RclInSpike_o, 0);
    chk({tag, "_rcl_vld"}, rclSpikeVld_o, 0);
    chk({tag, "_rcl_vaddr"}, rclAddrVld_o, 0);
    chk({tag, "_save"}, saveRclSpikes_o, 0);
    chk({tag, "_lrn_addr"}, LrnAxonAddr_o, 0);
    chk({tag, "_lrn_rden"}, rdEn_LrnInSpike_o, 0);
    chk({tag, "_lrn_vld"}, lrnSpikeVld_o, 0);
    chk({tag, "_lrn_vaddr"}, lrnAddrVld_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_overrun"}, overrun_o, 0);
    chk({tag, "_state"}, dbgState_o, IDLE);
  endtask

  // One time step: tick in cycle 0; rclRdy low in cycles rclLo..rclHi; extra ticks at tA/tB;
  // reset asserted in cycle abortC (if >= 0); rnd randomises both readies.
  task automatic run_step(input bit lrnSel, input int rclLo, input int rclHi,
                          input int tA, input int tB, input int abortC, input bit rnd);
    int         saveC, doneC;
    bit         prevRcl, prevLrn, expRcl, expLrn, expBusy, sweeping, reached;
    logic [W-1:0] prevRclA, prevLrnA, a;
    logic [2:0] expState;
    rcl_q.delete();
    lrn_q.delete();
    for (int i = 0; i < N; i++) begin
      rcl_q.push_back(W'(i));
      if (lrnSel) lrn_q.push_back(W'(i));
    end
    saveC = 1000; doneC = 1000;
    prevRcl = 0; prevLrn = 0; prevRclA = '0; prevLrnA = '0; reached = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == abortC) rst_n = 1'b0;
      tick   = (c == 0) || (c == tA) || (c == tB);
      lrnEn  = (c == 0) ? lrnSel : 1'($urandom_range(0, 1));
      rclRdy = rnd ? ($urandom_range(0, 3) != 0) : !(c >= rclLo && c <= rclHi);
      lrnRdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (abortC >= 0 && c >= abortC) begin
        chk_zero($sformatf("abort_c%0d", c));
        if (c == abortC + 3) begin reached = 1; break; end
        continue;
      end
      expBusy  = (c >= 1) && (c <= doneC);
      sweeping = (c >= 2) && (c < saveC);
      expState = (c == 1) ? LOAD : sweeping ? SWEEP : (c == saveC) ? SAVE :
                 (c == doneC) ? DONE : IDLE;
      chk($sformatf("start_c%0d", c), start_o, c == 1);
      chk($sformatf("busy_c%0d", c), busy_o, expBusy);
      chk($sformatf("overrun_c%0d", c), overrun_o, tick && expBusy);
      chk($sformatf("save_c%0d", c), saveRclSpikes_o, c == saveC);
      chk($sformatf("done_c%0d", c), done_o, c == doneC);
      chk($sformatf("state_c%0d", c), dbgState_o, expState);
      expRcl = sweeping && (rcl_q.size() > 0) && rclRdy;
      expLrn = sweeping && (lrn_q.size() > 0) && lrnRdy;
      chk($sformatf("rcl_rden_c%0d", c), rdEn_RclInSpike_o, expRcl);
      chk($sformatf("lrn_rden_c%0d", c), rdEn_LrnInSpike_o, expLrn);
      chk($sformatf("rcl_vld_c%0d", c), rclSpikeVld_o, prevRcl);
      chk($sformatf("lrn_vld_c%0d", c), lrnSpikeVld_o, prevLrn);
      if (prevRcl) chk($sformatf("rcl_vaddr_c%0d", c), rclAddrVld_o, prevRclA);
      if (prevLrn) chk($sformatf("lrn_vaddr_c%0d", c), lrnAddrVld_o, prevLrnA);
      if (expRcl) begin
        a = rcl_q.pop_front();
        chk($sformatf("rcl_addr_c%0d", c), RclAxonAddr_o, a);
        prevRclA = a;
      end
      if (expLrn) begin
        a = lrn_q.pop_front();
        chk($sformatf("lrn_addr_c%0d", c), LrnAxonAddr_o, a);
        prevLrnA = a;
      end
      prevRcl = expRcl;
      prevLrn = expLrn;
      if (saveC == 1000 && c >= 2 && rcl_q.size() == 0 && lrn_q.size() == 0) begin
        saveC = c + 1;
        doneC = c + 2;
      end
      if (c == doneC + 2) begin reached = 1; break; end
    end
    tick = 1'b0;
    chk("step_end_reached", reached, 1);
    if (abortC < 0) begin
      chk("rcl_q_drained", rcl_q.size(), 0);
      chk("lrn_q_drained", lrn_q.size(), 0);
    end else begin
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; lrnEn = 1'b0; rclRdy = 1'b1; lrnRdy = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    #1;
    chk_zero("reset");
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_step(1'b1, -1, -1, -1, -1, -1, 1'b0);
    run_step(1'b0, -1, -1, -1, -1, -1, 1'b0);
    run_step(1'b1,  4,  6, -1, -1, -1, 1'b0);
    run_step(1'b1, -1, -1,  5, 11, -1, 1'b0);
    run_step(1'b1, -1, -1, -1, -1,  6, 1'b0);
    run_step(1'b1, -1, -1, -1, -1, -1, 1'b0);
    repeat (3) run_step(1'b1, -1, -1, -1, -1, -1, 1'b1);
    run_step(1'b0, -1, -1, -1, -1, -1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
